// File: rtl/mpc_transformer_pkg.sv
// +----------------------------------------------------------------------------+
// | mpc_transformer_pkg : widths, default prediction tree, slot mapping helper |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package mpc_transformer_pkg;
  localparam int LINE_W    = 256;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = 32;

  // Prediction tree shared with the decompressor's detransform stage.
  localparam logic [7:0] DEF_ROOT_IDX = 8'd16;
  localparam logic [LINE_W-1:0] DEF_BASE_IDX = {
    8'd16, 8'd17, 8'd4,  8'd1,  8'd6,  8'd3,  8'd8,  8'd3,
    8'd10, 8'd3,  8'd12, 8'd3,  8'd14, 8'd3,  8'd16, 8'd3,
    8'd16, 8'd0,  8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd19,
    8'd22, 8'd19, 8'd24, 8'd19, 8'd26, 8'd19, 8'd28, 8'd19
  };
  localparam logic [LINE_W-1:0] DEF_SHIFT_VAL = {{17{8'h00}}, 8'hFA, {14{8'h00}}};

  // Output slot of byte j: root goes first, the rest keep index order.
  function automatic int slot_of(input int j, input int root);
    if (j == root)     return 0;
    else if (j < root) return j + 1;
    else               return j;
  endfunction
endpackage

`default_nettype wire

// File: rtl/mpc_transformer_core.sv
// +----------------------------------------------------------------------------+
// | mpc_transformer_core : combinational diff, shift, permute and zero mask    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mpc_transformer_core
  import mpc_transformer_pkg::*;
#(
  parameter logic [7:0]        ROOT_IDX  = DEF_ROOT_IDX,
  parameter logic [LINE_W-1:0] BASE_IDX  = DEF_BASE_IDX,
  parameter logic [LINE_W-1:0] SHIFT_VAL = DEF_SHIFT_VAL
) (
  input  logic [LINE_W-1:0]    line_i,
  input  logic                 bypass_i,
  output logic [LINE_W-1:0]    diff_o,
  output logic [NUM_BYTES-1:0] zero_mask_o
);
  logic [LINE_W-1:0] perm;

  if (ROOT_IDX > 8'd31) begin : g_bad_root
    $error("mpc_transformer: ROOT_IDX out of range");
  end

  for (genvar j = 0; j < NUM_BYTES; j++) begin : g_byte
    localparam int FIELD_LSB = LINE_W - BYTE_W * (j + 1);
    localparam int BASE_RAW  = int'(BASE_IDX[FIELD_LSB +: BYTE_W]);
    localparam logic signed [7:0] SHIFT8 = SHIFT_VAL[FIELD_LSB +: BYTE_W];
    localparam int SHIFT     = SHIFT8;
    localparam bit IS_ROOT   = (j == int'(ROOT_IDX));
    // Illegal or ignored base fields are clamped so indexing stays in range.
    localparam int BASE      = IS_ROOT ? j : ((BASE_RAW > NUM_BYTES - 1) ? 0 : BASE_RAW);
    localparam int SLOT      = slot_of(j, int'(ROOT_IDX));

    if (!IS_ROOT && (BASE_RAW > NUM_BYTES - 1 || BASE_RAW == j)) begin : g_bad_base
      $error("mpc_transformer: illegal BASE_IDX field");
    end
    if (SHIFT > 7 || SHIFT < -7) begin : g_bad_shift
      $error("mpc_transformer: SHIFT_VAL magnitude exceeds 7");
    end

    logic [BYTE_W-1:0] cur;
    logic [BYTE_W-1:0] base;
    logic [BYTE_W-1:0] pred;

    assign cur  = line_i[FIELD_LSB +: BYTE_W];
    assign base = line_i[LINE_W - BYTE_W * (BASE + 1) +: BYTE_W];

    if (SHIFT >= 0) begin : g_shl
      assign pred = base << SHIFT;
    end else begin : g_shr
      assign pred = base >> (-SHIFT);
    end

    assign perm[LINE_W - BYTE_W * (SLOT + 1) +: BYTE_W] = IS_ROOT ? cur : (cur - pred);
  end

  assign diff_o = bypass_i ? line_i : perm;

  for (genvar s = 0; s < NUM_BYTES; s++) begin : g_zero
    assign zero_mask_o[s] = (diff_o[LINE_W - BYTE_W * (s + 1) +: BYTE_W] == '0);
  end
endmodule

`default_nettype wire

// File: rtl/mpc_transformer.sv
// +----------------------------------------------------------------------------+
// | mpc_transformer : 2-stage elastic transform pipeline ahead of MPC encoder  |
// | Optional: MPC_TRANSFORMER_BYPASS_EN adds bypass_i / out_bypass_o. Rev 1.0  |
// +----------------------------------------------------------------------------+
`default_nettype none

module mpc_transformer
  import mpc_transformer_pkg::*;
#(
  parameter logic [7:0]        ROOT_IDX  = DEF_ROOT_IDX,
  parameter logic [LINE_W-1:0] BASE_IDX  = DEF_BASE_IDX,
  parameter logic [LINE_W-1:0] SHIFT_VAL = DEF_SHIFT_VAL
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [LINE_W-1:0]    line_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [LINE_W-1:0]    diff_o,
  output logic [NUM_BYTES-1:0] zero_mask_o
`ifdef MPC_TRANSFORMER_BYPASS_EN
  ,
  input  logic                 bypass_i,
  output logic                 out_bypass_o
`endif
);
  logic                 s1_valid_q, s1_valid_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [LINE_W-1:0]    s1_line_q, s1_line_d;
  logic [LINE_W-1:0]    diff_q, diff_d;
  logic [NUM_BYTES-1:0] mask_q, mask_d;
  logic                 s2_adv;
  logic                 accept;
  logic                 core_bypass;
  logic [LINE_W-1:0]    core_diff;
  logic [NUM_BYTES-1:0] core_mask;

  mpc_transformer_core #(
    .ROOT_IDX  (ROOT_IDX),
    .BASE_IDX  (BASE_IDX),
    .SHIFT_VAL (SHIFT_VAL)
  ) u_core (
    .line_i      (s1_line_q),
    .bypass_i    (core_bypass),
    .diff_o      (core_diff),
    .zero_mask_o (core_mask)
  );

  always_comb begin
    s2_adv     = s1_valid_q && (!s2_valid_q || out_ready_i);
    in_ready_o = !s1_valid_q || s2_adv;
    accept     = in_valid_i && in_ready_o;

    s1_valid_d = s1_valid_q;
    s1_line_d  = s1_line_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_line_d  = line_i;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    // S2 data only moves on advance, so a stalled output stays stable.
    s2_valid_d = s2_valid_q;
    diff_d     = diff_q;
    mask_d     = mask_q;
    if (s2_adv) begin
      s2_valid_d = 1'b1;
      diff_d     = core_diff;
      mask_d     = core_mask;
    end else if (out_ready_i) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_line_q  <= '0;
      diff_q     <= '0;
      mask_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_line_q  <= s1_line_d;
      diff_q     <= diff_d;
      mask_q     <= mask_d;
    end
  end

`ifdef MPC_TRANSFORMER_BYPASS_EN
  logic s1_byp_q, s1_byp_d;
  logic s2_byp_q, s2_byp_d;

  always_comb begin
    s1_byp_d = accept ? bypass_i : s1_byp_q;
    s2_byp_d = s2_adv ? s1_byp_q : s2_byp_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_byp_q <= 1'b0;
      s2_byp_q <= 1'b0;
    end else begin
      s1_byp_q <= s1_byp_d;
      s2_byp_q <= s2_byp_d;
    end
  end

  assign core_bypass  = s1_byp_q;
  assign out_bypass_o = s2_byp_q;
`else
  assign core_bypass = 1'b0;
`endif

  assign out_valid_o = s2_valid_q;
  assign diff_o      = diff_q;
  assign zero_mask_o = mask_q;
endmodule

`default_nettype wire

// File: tb/tb_mpc_transformer.sv
// +----------------------------------------------------------------------------+
// | tb_mpc_transformer : vector table, corner sequences, random round trip     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mpc_transformer;
  localparam int ROOT = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         bypass = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [255:0] line = '0;
  logic [255:0] diff;
  logic [31:0]  mask;
`ifdef MPC_TRANSFORMER_BYPASS_EN
  logic         out_bypass;
`endif

  always #5 clk = ~clk;

  mpc_transformer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .line_i      (line),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .diff_o      (diff),
    .zero_mask_o (mask)
`ifdef MPC_TRANSFORMER_BYPASS_EN
    ,
    .bypass_i    (bypass),
    .out_bypass_o(out_bypass)
`endif
  );

  int base_tab[32] = '{16,17,4,1,6,3,8,3,10,3,12,3,14,3,16,3,
                       16,0,16,17,18,19,20,19,22,19,24,19,26,19,28,19};
  int shift_tab[32];

  typedef struct {
    logic [255:0] d;
    logic [31:0]  m;
    logic         b;
    logic [255:0] l;
  } exp_t;

  typedef struct {
    logic [255:0] line;
    logic [255:0] d;
    logic [31:0]  m;
  } vec_t;

  exp_t         sbq[$];
  int           n_cmp = 0;
  int           n_fail = 0;
  int           n_out = 0;
  logic         acc_g;
  logic         obs_valid;
  logic [255:0] obs_diff;
  logic [31:0]  obs_mask;

  function automatic logic [7:0] pred_of(input logic [7:0] b, input int sh);
    int v;
    if (sh >= 0) v = (int'(b) * (1 << sh)) % 256;
    else         v = int'(b) / (1 << (-sh));
    return 8'(v);
  endfunction

  function automatic void model(input logic [255:0] l, input logic byp,
                                output logic [255:0] d, output logic [31:0] m);
    logic [7:0] b[32];
    logic [7:0] q[$];
    for (int j = 0; j < 32; j++) b[j] = l[255-8*j -: 8];
    d = l;
    if (!byp) begin
      q.push_back(b[ROOT]);
      for (int j = 0; j < 32; j++)
        if (j != ROOT) q.push_back(8'(b[j] - pred_of(b[base_tab[j]], shift_tab[j])));
      for (int s = 0; s < 32; s++) d[255-8*s -: 8] = q[s];
    end
    for (int s = 0; s < 32; s++) m[s] = (d[255-8*s -: 8] == 8'h00);
  endfunction

  // Detransform: rebuild bytes from the root outward along the base tree.
  function automatic logic [255:0] detx(input logic [255:0] d);
    logic [7:0]   dj[32];
    logic [7:0]   rec[32];
    bit           known[32];
    int           k;
    logic [255:0] r;
    k = 1;
    for (int j = 0; j < 32; j++) begin
      known[j] = 1'b0;
      rec[j]   = 8'h00;
      if (j == ROOT) dj[j] = d[255 -: 8];
      else begin
        dj[j] = d[255-8*k -: 8];
        k++;
      end
    end
    rec[ROOT]   = dj[ROOT];
    known[ROOT] = 1'b1;
    for (int p = 0; p < 32; p++)
      for (int j = 0; j < 32; j++)
        if (!known[j] && known[base_tab[j]]) begin
          rec[j]   = 8'(dj[j] + pred_of(rec[base_tab[j]], shift_tab[j]));
          known[j] = 1'b1;
        end
    for (int j = 0; j < 32; j++) r[255-8*j -: 8] = rec[j];
    return r;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    logic [7:0]   b;
    if ($urandom_range(0, 3) == 0) begin
      b = 8'($urandom);
      l = {32{b}};
    end else begin
      for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    end
    return l;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample after settle, score any output transfer.
  task automatic cycle(input logic v, input logic [255:0] l, input logic b, input logic r);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    line      = l;
    bypass    = b;
    out_ready = r;
    #1;
    acc_g     = v && in_ready;
    obs_valid = out_valid;
    obs_diff  = diff;
    obs_mask  = mask;
    if (acc_g) begin
      model(l, b, e.d, e.m);
      e.b = b;
      e.l = l;
      sbq.push_back(e);
    end
    if (out_valid && r) begin
      n_out++;
      if (sbq.size() == 0) begin
        chk("spurious_output", 256'(out_valid), 256'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_diff", diff, e.d);
        chk("sb_mask", 256'(mask), 256'(e.m));
`ifdef MPC_TRANSFORMER_BYPASS_EN
        chk("sb_bypass", 256'(out_bypass), 256'(e.b));
`endif
        if (!e.b) chk("roundtrip", detx(diff), e.l);
      end
    end
  endtask

  task automatic idle(input logic r);
    cycle(1'b0, '0, 1'b0, r);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vt[5];
    logic [255:0] l, la, ed;
    logic [31:0]  em;
    logic [255:0] pend[$];
    logic [6:0]   pat;
    int           acc_cnt, out_before, sent, budget;
    logic         v, b;

    for (int j = 0; j < 32; j++) shift_tab[j] = 0;
    shift_tab[17] = -6;

    vt[0] = '{{32{8'h5A}}, (256'h5A << 248) | (256'h59 << 112), 32'hFFFD_FFFE};
    vt[1] = '{{32{8'h00}}, 256'd0, 32'hFFFF_FFFF};
    vt[2] = '{{32{8'hFF}}, (256'hFF << 248) | (256'hFC << 112), 32'hFFFD_FFFE};
    vt[3] = '{{32{8'h80}}, (256'h80 << 248) | (256'h7E << 112), 32'hFFFD_FFFE};
    vt[4] = '{256'h01 << 120,
              (256'h01 << 248) | (256'hFF << 240) | (256'hFF << 128) | (256'hFF << 104),
              32'hFFFB_7FFC};

    #12;
    chk("rst_out_valid", 256'(out_valid), 256'd0);
    chk("rst_diff", diff, 256'd0);
    chk("rst_mask", 256'(mask), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 256'(in_ready), 256'd1);

    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, vt[i].line, 1'b0, 1'b1);
      chk("tbl_accept", 256'(acc_g), 256'd1);
      idle(1'b1);
      if (i == 0) chk("latency_not_early", 256'(obs_valid), 256'd0);
      idle(1'b1);
      chk("tbl_valid", 256'(obs_valid), 256'd1);
      chk("tbl_diff", obs_diff, vt[i].d);
      chk("tbl_mask", 256'(obs_mask), 256'(vt[i].m));
    end

    for (int k = 0; k < 32; k++) l[255-8*k -: 8] = 8'(k);
    cycle(1'b1, l, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("kk_slot0", 256'(obs_diff[255:248]), 256'h10);
    chk("kk_slot1", 256'(obs_diff[247:240]), 256'hF0);
    chk("kk_slot2", 256'(obs_diff[239:232]), 256'hF0);
    chk("kk_slot17", 256'(obs_diff[119:112]), 256'h11);

    pat = '0;
    for (int i = 0; i < 7; i++) begin
      cycle(i < 4, rand_line(), 1'b0, 1'b1);
      if (i < 4) chk("b2b_in_ready", 256'(in_ready), 256'd1);
      pat[i] = obs_valid;
    end
    chk("b2b_valid_pattern", 256'(pat), 256'(7'b0111100));

    la = rand_line();
    pend.push_back(la);
    pend.push_back(rand_line());
    pend.push_back(rand_line());
    model(la, 1'b0, ed, em);
    acc_cnt    = 0;
    out_before = n_out;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, pend[0], 1'b0, 1'b0);
      if (acc_g) begin
        void'(pend.pop_front());
        acc_cnt++;
      end
      if (i >= 2) begin
        chk("hold_in_ready", 256'(in_ready), 256'd0);
        chk("hold_valid", 256'(obs_valid), 256'd1);
        chk("hold_diff", obs_diff, ed);
        chk("hold_mask", 256'(obs_mask), 256'(em));
      end
    end
    chk("hold_accepted", 256'(acc_cnt), 256'd2);
    budget = 0;
    while ((pend.size() > 0 || sbq.size() > 0) && budget < 20) begin
      if (pend.size() > 0) begin
        cycle(1'b1, pend[0], 1'b0, 1'b1);
        if (acc_g) void'(pend.pop_front());
      end else begin
        idle(1'b1);
      end
      budget++;
    end
    chk("hold_drain_count", 256'(n_out - out_before), 256'd3);

    cycle(1'b1, rand_line(), 1'b0, 1'b0);
    cycle(1'b1, rand_line(), 1'b0, 1'b0);
    idle(1'b0);
    chk("fill_valid", 256'(obs_valid), 256'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 256'(out_valid), 256'd0);
    chk("arst_diff", diff, 256'd0);
    chk("arst_mask", 256'(mask), 256'd0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    l = rand_line();
    model(l, 1'b0, ed, em);
    cycle(1'b1, l, 1'b0, 1'b1);
    chk("post_rst_accept", 256'(acc_g), 256'd1);
    idle(1'b1);
    chk("post_rst_no_stale", 256'(obs_valid), 256'd0);
    idle(1'b1);
    chk("post_rst_valid", 256'(obs_valid), 256'd1);
    chk("post_rst_diff", obs_diff, ed);

    sent   = 0;
    budget = 0;
    l      = rand_line();
    b      = 1'b0;
    while (sent < 1000 && budget < 20000) begin
      v = ($urandom_range(0, 3) != 0);
      cycle(v, l, b, $urandom_range(0, 3) != 0);
      if (acc_g) begin
        sent++;
        l = rand_line();
`ifdef MPC_TRANSFORMER_BYPASS_EN
        b = ($urandom_range(0, 3) == 0);
`endif
      end
      budget++;
    end
    chk("random_sent", 256'(sent), 256'd1000);
    budget = 0;
    while (sbq.size() > 0 && budget < 50) begin
      idle(1'b1);
      budget++;
    end
    chk("final_drain", 256'(sbq.size()), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
